// File: rtl/proc_n.sv
// proc_n: parametrised multi-cycle processor core with a shared operand bus and a debug read port.
// Optional condition flags (Zf, Cf) are enabled by defining PROC_FLAGS_EN.
module proc_n #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Run,
  input  logic [2:0]       Fun,
  input  logic [RW-1:0]    Rx,
  input  logic [RW-1:0]    Ry,
  input  logic [WIDTH-1:0] Data,
  output logic             Done,
  output logic             Busy,
  output logic [WIDTH-1:0] BusWires,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
`ifdef PROC_FLAGS_EN
  ,
  output logic             Zf,
  output logic             Cf
`endif
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MVI = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  state_t           state, state_next;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_reg, g_reg, data_q;
  logic [2:0]       fun_q;
  logic [RW-1:0]    rx_q, ry_q;
  logic [WIDTH:0]   alu_out;
  logic             is_move;

  assign is_move  = (fun_q[2:1] == 2'b00);
  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = (state != IDLE);
    Done       = 1'b0;
    BusWires   = '0;
    case (state)
      IDLE: if (Run) state_next = T1;
      T1: begin
        if (fun_q == OP_MVI)  BusWires = data_q;
        else if (is_move)     BusWires = regs[ry_q];
        else                  BusWires = regs[rx_q];
        if (is_move) begin
          Done       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = T2;
        end
      end
      T2: begin
        BusWires   = regs[ry_q];
        state_next = T3;
      end
      T3: begin
        BusWires   = g_reg;
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit WIDTH of the ALU result carries the carry, borrow or last shifted-out bit.
  always_comb begin
    alu_out = '0;
    case (fun_q)
      OP_ADD: alu_out = {1'b0, a_reg} + {1'b0, BusWires};
      OP_SUB: alu_out = {1'b0, a_reg} - {1'b0, BusWires};
      OP_AND: alu_out = {1'b0, a_reg & BusWires};
      OP_OR:  alu_out = {1'b0, a_reg | BusWires};
      OP_XOR: alu_out = {1'b0, a_reg ^ BusWires};
      OP_SHL: alu_out = {1'b0, a_reg} << BusWires;
      default: alu_out = '0;
    endcase
  end

`ifndef PROC_FLAGS_EN
  logic unused_carry;
  assign unused_carry = alu_out[WIDTH];
`else
  logic carry_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      a_reg  <= '0;
      g_reg  <= '0;
      data_q <= '0;
      fun_q  <= '0;
      rx_q   <= '0;
      ry_q   <= '0;
`ifdef PROC_FLAGS_EN
      carry_q <= 1'b0;
      Zf      <= 1'b0;
      Cf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (Run) begin
          fun_q  <= Fun;
          rx_q   <= Rx;
          ry_q   <= Ry;
          data_q <= Data;
        end
        T1: begin
          if (is_move) regs[rx_q] <= BusWires;
          else         a_reg      <= BusWires;
        end
        T2: begin
          g_reg <= alu_out[WIDTH-1:0];
`ifdef PROC_FLAGS_EN
          carry_q <= alu_out[WIDTH];
`endif
        end
        T3: begin
          regs[rx_q] <= g_reg;
`ifdef PROC_FLAGS_EN
          Zf <= (g_reg == '0);
          Cf <= carry_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_n.sv
// tb_proc_n: self-checking bench for proc_n at 8x8 and 16x16 against a behavioural reference model.
module tb_proc_n;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int WW = 16;
  localparam int WN = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [2:0]    fun;
  logic [2:0]    rx, ry, dbg_sel;
  logic [W-1:0]  data, bus_wires, dbg_data;
  logic          done, busy;

  logic          w_run;
  logic [2:0]    w_fun;
  logic [3:0]    w_rx, w_ry, w_dbg_sel;
  logic [WW-1:0] w_data, w_bus_wires, w_dbg_data;
  logic          w_done, w_busy;
`ifdef PROC_FLAGS_EN
  logic          zf, cf, w_zf, w_cf;
`endif

  int errors = 0;
  int checks = 0;
  int model [N];
  int w_model [WN];
  bit m_zf, m_cf;

  always #5 clk = ~clk;

  proc_n #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .reset(reset), .Run(run), .Fun(fun), .Rx(rx), .Ry(ry), .Data(data),
    .Done(done), .Busy(busy), .BusWires(bus_wires), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`ifdef PROC_FLAGS_EN
    , .Zf(zf), .Cf(cf)
`endif
  );

  proc_n #(.WIDTH(WW), .NREGS(WN)) dut_wide (
    .clk(clk), .reset(reset), .Run(w_run), .Fun(w_fun), .Rx(w_rx), .Ry(w_ry), .Data(w_data),
    .Done(w_done), .Busy(w_busy), .BusWires(w_bus_wires), .dbg_sel(w_dbg_sel), .dbg_data(w_dbg_data)
`ifdef PROC_FLAGS_EN
    , .Zf(w_zf), .Cf(w_cf)
`endif
  );

  // Reference semantics of each opcode; c returns carry/borrow/last shifted-out bit.
  function automatic int ref_result(input int f, input int x, input int y, input int d,
                                    input int width, output bit c);
    int mask;
    int r;
    mask = (1 << width) - 1;
    c = 1'b0;
    r = 0;
    case (f)
      0: r = d;
      1: r = y;
      2: begin r = x + y; c = (r > mask); end
      3: begin c = (x < y); r = x - y; end
      4: r = x & y;
      5: r = x | y;
      6: r = x ^ y;
      default: begin
        r = (y >= width) ? 0 : (x << y);
        if (y >= 1 && y <= width) c = bit'((x >> (width - y)) & 1);
      end
    endcase
    return r & mask;
  endfunction

  task automatic read_reg(input int idx, output int val);
    dbg_sel = 3'(idx);
    #1;
    val = int'(dbg_data);
  endtask

  task automatic do_instr(input int f, input int rxi, input int ryi, input int d);
    int exp_bus [3];
    int got_bus [$];
    int nb, res, cycles, got;
    bit c;
    res = ref_result(f, model[rxi], model[ryi], d, W, c);
    if (f < 2) begin
      exp_bus[0] = (f == 0) ? d : model[ryi];
      nb = 1;
    end else begin
      exp_bus[0] = model[rxi];
      exp_bus[1] = model[ryi];
      exp_bus[2] = res;
      nb = 3;
    end
    @(negedge clk);
    fun = 3'(f); rx = 3'(rxi); ry = 3'(ryi); data = 8'(d); run = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      run = 1'b0;
      fun = 3'($urandom); rx = 3'($urandom); ry = 3'($urandom); data = 8'($urandom);
      cycles++;
      got_bus.push_back(int'(bus_wires));
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL busy_active: op %0d cycle %0d got %b expected 1", f, cycles, busy);
      end
    end while (done !== 1'b1 && cycles < 8);
    checks++;
    if (done !== 1'b1 || cycles != nb) begin
      errors++;
      $display("[TB] FAIL latency: op %0d got %0d cycles (done=%b) expected %0d", f, cycles, done, nb);
    end
    for (int i = 0; i < nb && i < got_bus.size(); i++) begin
      checks++;
      if (got_bus[i] !== exp_bus[i]) begin
        errors++;
        $display("[TB] FAIL bus: op %0d step %0d got %h expected %h", f, i, got_bus[i], exp_bus[i]);
      end
    end
    model[rxi] = res;
    if (f >= 2) begin
      m_zf = (res == 0);
      m_cf = c;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after: op %0d got busy=%b done=%b expected 0/0", f, busy, done);
    end
    read_reg(rxi, got);
    checks++;
    if (got !== model[rxi]) begin
      errors++;
      $display("[TB] FAIL result: op %0d R%0d got %h expected %h", f, rxi, got, model[rxi]);
    end
`ifdef PROC_FLAGS_EN
    checks++;
    if (zf !== m_zf || cf !== m_cf) begin
      errors++;
      $display("[TB] FAIL flags: op %0d got Zf=%b Cf=%b expected Zf=%b Cf=%b", f, zf, cf, m_zf, m_cf);
    end
`endif
  endtask

  task automatic check_const(input string name, input int idx, input int expv);
    int got;
    read_reg(idx, got);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: R%0d got %h expected %h", name, idx, got, expv);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < N; i++) check_const(name, i, 0);
  endtask

  task automatic test_reset;
    run = 0; fun = 0; rx = 0; ry = 0; data = 0; dbg_sel = 0;
    w_run = 0; w_fun = 0; w_rx = 0; w_ry = 0; w_data = 0; w_dbg_sel = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bus_wires !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got done=%b busy=%b bus=%h expected 0/0/00", done, busy, bus_wires);
    end
`ifdef PROC_FLAGS_EN
    checks++;
    if (zf !== 1'b0 || cf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got Zf=%b Cf=%b expected 0/0", zf, cf);
    end
`endif
    check_all_zero("reset_regs");
    for (int i = 0; i < N; i++) model[i] = 0;
    m_zf = 0; m_cf = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed;
    do_instr(0, 0, 0, 8'h33);
    do_instr(0, 1, 0, 8'h22);
    do_instr(0, 2, 0, 8'h11);
    check_const("mvi_r0", 0, 8'h33);
    check_const("mvi_r2", 2, 8'h11);
    do_instr(2, 0, 1, 0);
    check_const("add_r0", 0, 8'h55);
    do_instr(3, 2, 1, 0);
    check_const("sub_wrap", 2, 8'hEF);
    do_instr(1, 7, 0, 0);
    check_const("mv_r7", 7, 8'h55);
    do_instr(2, 1, 1, 0);
    check_const("add_same", 1, 8'h44);
    do_instr(3, 3, 3, 0);
    check_const("sub_same", 3, 8'h00);
    do_instr(6, 0, 0, 0);
    check_const("xor_same", 0, 8'h00);
    do_instr(0, 4, 0, 9);
    do_instr(0, 5, 0, 8'h81);
    do_instr(7, 5, 4, 0);
    check_const("shl_by_9", 5, 8'h00);
    do_instr(0, 4, 0, 3);
    do_instr(0, 5, 0, 8'h31);
    do_instr(7, 5, 4, 0);
    check_const("shl_by_3", 5, 8'h88);
  endtask

  task automatic test_run_ignored;
    int res;
    bit c;
    res = ref_result(2, model[0], model[1], 0, W, c);
    @(negedge clk);
    fun = 3'd2; rx = 3'd0; ry = 3'd1; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    fun = 3'd0; rx = 3'd6; data = 8'hAA; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_done: got %b expected 1", done);
    end
    model[0] = res;
    m_zf = (res == 0);
    m_cf = c;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL run_not_queued: got busy=%b expected 0", busy);
      end
    end
    check_const("ignored_orig", 0, model[0]);
    check_const("ignored_other", 6, model[6]);
  endtask

  task automatic test_back_to_back;
    do_instr(0, 6, 0, 1);
    @(negedge clk);
    fun = 3'd2; rx = 3'd6; ry = 3'd6; run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'((k % 4) == 3)) begin
        errors++;
        $display("[TB] FAIL b2b_alu_done: cycle %0d got %b expected %b", k, done, ((k % 4) == 3));
      end
    end
    run = 1'b0;
    model[6] = 8;
    m_zf = 0; m_cf = 0;
    @(negedge clk);
    check_const("b2b_alu_result", 6, 8);
    fun = 3'd0; rx = 3'd7; data = 8'h5A; run = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'((k % 2) == 1)) begin
        errors++;
        $display("[TB] FAIL b2b_mvi_done: cycle %0d got %b expected %b", k, done, ((k % 2) == 1));
      end
    end
    run = 1'b0;
    model[7] = 8'h5A;
    @(negedge clk);
    check_const("b2b_mvi_result", 7, 8'h5A);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      do_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)),
               int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
  endtask

`ifdef PROC_FLAGS_EN
  task automatic test_flags;
    do_instr(0, 0, 0, 8'hFF);
    do_instr(0, 1, 0, 8'h01);
    do_instr(2, 0, 1, 0);
    checks++;
    if (zf !== 1'b1 || cf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flags_add_ovf: got Zf=%b Cf=%b expected 1/1", zf, cf);
    end
    check_const("flags_add_res", 0, 8'h00);
    do_instr(0, 2, 0, 8'h01);
    do_instr(0, 3, 0, 8'h02);
    do_instr(3, 2, 3, 0);
    checks++;
    if (zf !== 1'b0 || cf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flags_sub_brw: got Zf=%b Cf=%b expected 0/1", zf, cf);
    end
    check_const("flags_sub_res", 2, 8'hFF);
  endtask
`endif

  task automatic test_reset_abort;
    @(negedge clk);
    fun = 3'd3; rx = 3'd2; ry = 3'd1; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus_wires !== 8'h00) begin
      errors++;
      $display("[TB] FAIL abort_async: got busy=%b done=%b bus=%h expected 0/0/00", busy, done, bus_wires);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_done: got %b expected 0", done);
      end
    end
    check_all_zero("abort_regs");
    reset = 1'b1;
    for (int i = 0; i < N; i++) model[i] = 0;
    m_zf = 0; m_cf = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_release: got busy=%b done=%b expected 0/0", busy, done);
      end
    end
  endtask

  task automatic w_instr(input int f, input int rxi, input int ryi, input int d, input int lat);
    int cycles;
    bit c;
    int res;
    res = ref_result(f, w_model[rxi], w_model[ryi], d, WW, c);
    @(negedge clk);
    w_fun = 3'(f); w_rx = 4'(rxi); w_ry = 4'(ryi); w_data = 16'(d); w_run = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      w_run = 1'b0;
      cycles++;
    end while (w_done !== 1'b1 && cycles < 8);
    checks++;
    if (w_done !== 1'b1 || cycles != lat) begin
      errors++;
      $display("[TB] FAIL wide_latency: op %0d got %0d cycles expected %0d", f, cycles, lat);
    end
    w_model[rxi] = res;
    @(negedge clk);
    w_dbg_sel = 4'(rxi);
    #1;
    checks++;
    if (int'(w_dbg_data) !== w_model[rxi]) begin
      errors++;
      $display("[TB] FAIL wide_result: op %0d R%0d got %h expected %h", f, rxi, w_dbg_data, w_model[rxi]);
    end
  endtask

  task automatic test_wide;
    for (int i = 0; i < WN; i++) w_model[i] = 0;
    w_instr(0, 0, 0, 16'h3333, 1);
    w_instr(0, 1, 0, 16'h2222, 1);
    w_instr(0, 15, 0, 16'h1111, 1);
    w_instr(2, 0, 1, 0, 3);
    w_instr(3, 15, 1, 0, 3);
    checks++;
    if (w_dbg_data !== 16'hEEEF) begin
      errors++;
      $display("[TB] FAIL wide_sub_wrap: got %h expected eeef", w_dbg_data);
    end
    w_instr(1, 9, 0, 0, 1);
    checks++;
    if (w_dbg_data !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL wide_mv: got %h expected 5555", w_dbg_data);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting proc_n bench");
    test_reset();
    test_directed();
    test_run_ignored();
    test_back_to_back();
`ifdef PROC_FLAGS_EN
    test_flags();
`endif
    test_random();
    test_reset_abort();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
